// File: rtl/vga_timing.sv
// VGA raster timing generator: scan counters, sync windows and a registered colour/sync output stage.
// Latency: colour and sync appear 1 clk after curr_x/curr_y present the coordinate. No backpressure: free-running.
// Optional VGA_FRAME_TICK_EN compiles in a one-cycle frame_tick at the start of vertical blanking.
module vga_timing #(
    parameter int   H_ACTIVE = 1440,
    parameter int   H_FP     = 80,
    parameter int   H_SYNC   = 152,
    parameter int   H_BP     = 232,
    parameter int   V_ACTIVE = 900,
    parameter int   V_FP     = 3,
    parameter int   V_SYNC   = 6,
    parameter int   V_BP     = 25,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [10:0] curr_x,
    output logic [10:0] curr_y,
    input  logic [3:0]  draw_r,
    input  logic [3:0]  draw_g,
    input  logic [3:0]  draw_b,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        frame_tick
);

    localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
    localparam logic [10:0] H_HS0  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_HS1  = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] H_LAST = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
    localparam logic [10:0] V_VS0  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_VS1  = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] V_LAST = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    logic [10:0] hc_q, hc_d;
    logic [10:0] vc_q, vc_d;
    logic [3:0]  vga_r_q, vga_r_d;
    logic [3:0]  vga_g_q, vga_g_d;
    logic [3:0]  vga_b_q, vga_b_d;
    logic        vga_hs_q, vga_hs_d;
    logic        vga_vs_q, vga_vs_d;
    logic        h_wrap, active, hs_win, vs_win;

    always_comb begin
        h_wrap = (hc_q == H_LAST);
        hc_d   = h_wrap ? 11'd0 : hc_q + 11'd1;
        vc_d   = vc_q;
        // vertical counter only moves (and only wraps) on a line wrap
        if (h_wrap) begin
            vc_d = (vc_q == V_LAST) ? 11'd0 : vc_q + 11'd1;
        end

        active = (hc_q < H_ACT) && (vc_q < V_ACT);
        hs_win = (hc_q >= H_HS0) && (hc_q < H_HS1);
        vs_win = (vc_q >= V_VS0) && (vc_q < V_VS1);

        vga_r_d  = active ? draw_r : 4'd0;
        vga_g_d  = active ? draw_g : 4'd0;
        vga_b_d  = active ? draw_b : 4'd0;
        vga_hs_d = hs_win ? HS_POL : ~HS_POL;
        vga_vs_d = vs_win ? VS_POL : ~VS_POL;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hc_q     <= 11'd0;
            vc_q     <= 11'd0;
            vga_r_q  <= 4'd0;
            vga_g_q  <= 4'd0;
            vga_b_q  <= 4'd0;
            vga_hs_q <= ~HS_POL;
            vga_vs_q <= ~VS_POL;
        end else begin
            hc_q     <= hc_d;
            vc_q     <= vc_d;
            vga_r_q  <= vga_r_d;
            vga_g_q  <= vga_g_d;
            vga_b_q  <= vga_b_d;
            vga_hs_q <= vga_hs_d;
            vga_vs_q <= vga_vs_d;
        end
    end

    assign curr_x = hc_q;
    assign curr_y = vc_q;
    assign vga_r  = vga_r_q;
    assign vga_g  = vga_g_q;
    assign vga_b  = vga_b_q;
    assign vga_hs = vga_hs_q;
    assign vga_vs = vga_vs_q;

`ifdef VGA_FRAME_TICK_EN
    logic frame_tick_q, frame_tick_d;

    // pulse lands in the same output stage as the colour for (0, V_ACTIVE)
    always_comb begin
        frame_tick_d = (hc_q == 11'd0) && (vc_q == V_ACT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_tick_q <= 1'b0;
        end else begin
            frame_tick_q <= frame_tick_d;
        end
    end

    assign frame_tick = frame_tick_q;
`else
    assign frame_tick = 1'b0;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench for vga_timing using a shrunken raster (25 x 13 clocks) so full frames fit in a short run.
module tb_vga_timing;

    localparam int HA = 16, HF = 2, HS = 3, HB = 4;
    localparam int VA = 8,  VF = 1, VS = 2, VB = 2;
    localparam int HT = HA + HF + HS + HB;   // 25
    localparam int VT = VA + VF + VS + VB;   // 13
    localparam int FRAME = HT * VT;          // 325

    logic        clk;
    logic        rst;
    logic [10:0] curr_x, curr_y;
    logic [3:0]  draw_r, draw_g, draw_b;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        vga_hs, vga_vs, frame_tick;

    logic        ramp_mode;
    logic [3:0]  fix_r, fix_g, fix_b;

    int total = 0;
    int bad   = 0;

    vga_timing #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b1)
    ) dut (
        .clk(clk), .rst(rst),
        .curr_x(curr_x), .curr_y(curr_y),
        .draw_r(draw_r), .draw_g(draw_g), .draw_b(draw_b),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .frame_tick(frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // draw controller stand-in: either a fixed colour or a ramp following curr_x
    always_comb begin
        draw_r = ramp_mode ? curr_x[3:0] : fix_r;
        draw_g = fix_g;
        draw_b = fix_b;
    end

    task automatic wait_coord(input int x, input int y, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            if (curr_x == 11'(x) && curr_y == 11'(y)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (5) @(negedge clk);
        total++; if (curr_x !== 11'd0 || curr_y !== 11'd0) begin bad++; $display("FAIL reset_coord x=%0d y=%0d want 0,0", curr_x, curr_y); end
        total++; if ({vga_r, vga_g, vga_b} !== 12'h000) begin bad++; $display("FAIL reset_rgb got %h want 000", {vga_r, vga_g, vga_b}); end
        total++; if (vga_hs !== 1'b1 || vga_vs !== 1'b0) begin bad++; $display("FAIL reset_sync hs=%b vs=%b want 1,0", vga_hs, vga_vs); end
        total++; if (frame_tick !== 1'b0) begin bad++; $display("FAIL reset_tick got %b want 0", frame_tick); end
        rst = 1'b1;
        @(negedge clk);
        total++; if (curr_x !== 11'd1 || curr_y !== 11'd0) begin bad++; $display("FAIL reset_release x=%0d y=%0d want 1,0", curr_x, curr_y); end
    endtask

    task automatic test_line_wrap;
        bit ok;
        wait_coord(HT - 1, 0, ok);
        total++; if (!ok) begin bad++; $display("FAIL line_wrap_timeout got no (24,0) want reached"); end
        @(negedge clk);
        total++; if (curr_x !== 11'd0 || curr_y !== 11'd1) begin bad++; $display("FAIL line_wrap x=%0d y=%0d want 0,1", curr_x, curr_y); end
    endtask

    task automatic test_frame_wrap;
        bit ok;
        int n;
        wait_coord(HT - 1, VT - 1, ok);
        total++; if (!ok) begin bad++; $display("FAIL frame_wrap_timeout got no (24,12) want reached"); end
        @(negedge clk);
        total++; if (curr_x !== 11'd0 || curr_y !== 11'd0) begin bad++; $display("FAIL frame_wrap x=%0d y=%0d want 0,0", curr_x, curr_y); end
        n = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            n++;
            if (curr_x == 11'd0 && curr_y == 11'd0) break;
        end
        total++; if (n != 325) begin bad++; $display("FAIL frame_period got %0d want 325", n); end
    endtask

    task automatic test_hsync;
        bit ok;
        int lows, first_x, last_x;
        lows = 0; first_x = -1; last_x = -1;
        wait_coord(0, 2, ok);
        total++; if (!ok) begin bad++; $display("FAIL hsync_timeout got no (0,2) want reached"); end
        for (int i = 0; i < HT; i++) begin
            @(negedge clk);
            if (vga_hs == 1'b0) begin
                lows++;
                if (first_x < 0) first_x = int'(curr_x);
                last_x = int'(curr_x);
            end
        end
        total++; if (lows != 3) begin bad++; $display("FAIL hsync_width got %0d want 3", lows); end
        total++; if (first_x != 19 || last_x != 21) begin bad++; $display("FAIL hsync_place got %0d..%0d want 19..21", first_x, last_x); end
    endtask

    task automatic test_vsync;
        bit ok;
        int highs, fx, fy;
        highs = 0; fx = -1; fy = -1;
        wait_coord(0, 0, ok);
        total++; if (!ok) begin bad++; $display("FAIL vsync_timeout got no (0,0) want reached"); end
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            if (vga_vs == 1'b1) begin
                highs++;
                if (fx < 0) begin fx = int'(curr_x); fy = int'(curr_y); end
            end
        end
        total++; if (highs != 50) begin bad++; $display("FAIL vsync_width got %0d want 50", highs); end
        total++; if (fx != 1 || fy != 9) begin bad++; $display("FAIL vsync_start got (%0d,%0d) want (1,9)", fx, fy); end
    endtask

    task automatic test_blanking;
        bit ok;
        ramp_mode = 1'b0; fix_r = 4'hF; fix_g = 4'hF; fix_b = 4'hF;
        wait_coord(1, 0, ok);
        total++; if (!ok || {vga_r, vga_g, vga_b} !== 12'hFFF) begin bad++; $display("FAIL blank_first got %h want fff", {vga_r, vga_g, vga_b}); end
        wait_coord(16, 0, ok);
        total++; if (!ok || vga_r !== 4'hF) begin bad++; $display("FAIL blank_last_active got %h want f", vga_r); end
        @(negedge clk);
        total++; if (vga_r !== 4'h0) begin bad++; $display("FAIL blank_h got %h want 0", vga_r); end
        wait_coord(0, 1, ok);
        total++; if (!ok || vga_r !== 4'h0) begin bad++; $display("FAIL blank_hbp got %h want 0", vga_r); end
        wait_coord(1, 7, ok);
        total++; if (!ok || {vga_r, vga_g, vga_b} !== 12'hFFF) begin bad++; $display("FAIL blank_last_line got %h want fff", {vga_r, vga_g, vga_b}); end
        wait_coord(1, 8, ok);
        total++; if (!ok || {vga_r, vga_g, vga_b} !== 12'h000) begin bad++; $display("FAIL blank_v got %h want 000", {vga_r, vga_g, vga_b}); end
        fix_r = 4'hA; fix_g = 4'h5; fix_b = 4'h3;
        wait_coord(5, 3, ok);
        total++; if (!ok || {vga_r, vga_g, vga_b} !== 12'hA53) begin bad++; $display("FAIL colour_pattern got %h want a53", {vga_r, vga_g, vga_b}); end
    endtask

    task automatic test_latency;
        bit ok;
        ramp_mode = 1'b1;
        wait_coord(3, 4, ok);
        total++; if (!ok || vga_r !== 4'h2) begin bad++; $display("FAIL ramp_x2 got %h want 2", vga_r); end
        wait_coord(15, 4, ok);
        total++; if (!ok || vga_r !== 4'hE) begin bad++; $display("FAIL ramp_x14 got %h want e", vga_r); end
        @(negedge clk);
        total++; if (vga_r !== 4'hF) begin bad++; $display("FAIL ramp_x15 got %h want f", vga_r); end
        ramp_mode = 1'b0;
    endtask

    task automatic test_frame_tick;
        bit ok;
        int pulses, px, py;
        pulses = 0; px = -1; py = -1;
        wait_coord(0, 0, ok);
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) begin
                pulses++;
                px = int'(curr_x); py = int'(curr_y);
            end
        end
`ifdef VGA_FRAME_TICK_EN
        total++; if (pulses != 2) begin bad++; $display("FAIL tick_count got %0d want 2", pulses); end
        total++; if (px != 1 || py != 8) begin bad++; $display("FAIL tick_place got (%0d,%0d) want (1,8)", px, py); end
`else
        total++; if (pulses != 0) begin bad++; $display("FAIL tick_off got %0d pulses at (%0d,%0d) want 0", pulses, px, py); end
`endif
    endtask

    task automatic test_mid_reset;
        bit ok;
        wait_coord(5, 10, ok);
        total++; if (!ok || vga_vs !== 1'b1) begin bad++; $display("FAIL midrst_pre vs=%b want 1", vga_vs); end
        #2 rst = 1'b0;
        #1;
        total++; if (curr_x !== 11'd0 || curr_y !== 11'd0 || vga_vs !== 1'b0 || vga_hs !== 1'b1) begin
            bad++; $display("FAIL midrst_async x=%0d y=%0d hs=%b vs=%b want 0,0,1,0", curr_x, curr_y, vga_hs, vga_vs);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++; if (curr_x !== 11'd1 || curr_y !== 11'd0 || vga_vs !== 1'b0) begin
            bad++; $display("FAIL midrst_restart x=%0d y=%0d vs=%b want 1,0,0", curr_x, curr_y, vga_vs);
        end
    endtask

    initial begin
        ramp_mode = 1'b0;
        fix_r = 4'h0; fix_g = 4'h0; fix_b = 4'h0;
        test_reset();
        test_line_wrap();
        test_frame_wrap();
        test_hsync();
        test_vsync();
        test_blanking();
        test_latency();
        test_frame_tick();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
